z80fi_recorder: RTL and testbench

Per-instruction trace capture that sits between the Z80 core and the z80fi instruction-spec checkers. It watches the core's fetch, memory-read and memory-write strobes plus a register snapshot. From these it assembles one z80fi retirement packet per instruction: instruction bytes, length, registers in/out, and up to two reads and two writes. It pulses `z80fi_valid` for one cycle per packet, and the spec modules compare the packet against their `spec_*` outputs.

---
 rtl/z80fi_recorder.sv | 177 +++++++++++++++++
 tb/tb_z80fi_recorder.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80fi_recorder.sv
// z80fi_recorder: assembles one z80fi retirement packet per instruction from fetch/read/write strobes.
// Define Z80FI_ORDER_EN to add the z80fi_order retirement sequence counter and port.
module z80fi_recorder (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         insn_start,
    input  logic         insn_retire,
    input  logic         fetch_valid,
    input  logic [7:0]   fetch_data,
    input  logic         rd_valid,
    input  logic [15:0]  rd_addr,
    input  logic [7:0]   rd_data,
    input  logic         wr_valid,
    input  logic [15:0]  wr_addr,
    input  logic [7:0]   wr_data,
    input  logic [207:0] core_regs,
    output logic         z80fi_valid,
    output logic [31:0]  z80fi_insn,
    output logic [2:0]   z80fi_insn_len,
    output logic [207:0] z80fi_regs_in,
    output logic [207:0] z80fi_regs_out,
    output logic [15:0]  z80fi_bus_raddr,
    output logic [15:0]  z80fi_bus_raddr2,
    output logic [15:0]  z80fi_bus_waddr,
    output logic [15:0]  z80fi_bus_waddr2,
    output logic [7:0]   z80fi_bus_rdata,
    output logic [7:0]   z80fi_bus_rdata2,
    output logic [7:0]   z80fi_bus_wdata,
    output logic [7:0]   z80fi_bus_wdata2,
    output logic [1:0]   z80fi_mem_rd,
    output logic [1:0]   z80fi_mem_wr,
    output logic         z80fi_overflow
`ifdef Z80FI_ORDER_EN
    ,
    output logic [31:0]  z80fi_order
`endif
);
    typedef enum logic {IDLE, OPEN} state_t;
    state_t state, state_nx;
    logic [31:0] insn_buf, m_insn;
    logic [2:0] len, m_len;
    logic [1:0][15:0] ra, wa, m_ra, m_wa;
    logic [1:0][7:0] rd, wd, m_rd, m_wd;
    logic [1:0] rused, wused, m_rused, m_wused;
    logic ovf, m_ovf;
    logic [207:0] regs_in_buf;
    logic retire_pkt;
    assign retire_pkt = (state == OPEN) && insn_retire;
    always_comb begin
        state_nx = insn_start ? OPEN : (state == OPEN && !insn_retire) ? OPEN : IDLE;
    end
    // Buffer contents with this cycle's events folded in; used both to advance and to emit.
    always_comb begin
        m_insn = insn_buf;
        m_len = len;
        m_ovf = ovf;
        m_ra = ra;
        m_rd = rd;
        m_rused = rused;
        m_wa = wa;
        m_wd = wd;
        m_wused = wused;
        if (fetch_valid) begin
            if (len[2]) m_ovf = 1'b1;
            else begin
                m_insn[{len[1:0], 3'b000} +: 8] = fetch_data;
                m_len = len + 3'd1;
            end
        end
        if (rd_valid) begin
            if (rused[1]) m_ovf = 1'b1;
            else begin
                m_ra[rused[0]] = rd_addr;
                m_rd[rused[0]] = rd_data;
                m_rused = {rused[0], 1'b1};
            end
        end
        if (wr_valid) begin
            if (wused[1]) m_ovf = 1'b1;
            else begin
                m_wa[wused[0]] = wr_addr;
                m_wd[wused[0]] = wr_data;
                m_wused = {wused[0], 1'b1};
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            insn_buf <= '0;
            len <= '0;
            ra <= '0;
            rd <= '0;
            rused <= '0;
            wa <= '0;
            wd <= '0;
            wused <= '0;
            ovf <= 1'b0;
            regs_in_buf <= '0;
        end else begin
            state <= state_nx;
            if (insn_start) begin
                insn_buf <= '0;
                len <= '0;
                ra <= '0;
                rd <= '0;
                rused <= '0;
                wa <= '0;
                wd <= '0;
                wused <= '0;
                ovf <= 1'b0;
                regs_in_buf <= core_regs;
            end else if (state == OPEN) begin
                insn_buf <= m_insn;
                len <= m_len;
                ra <= m_ra;
                rd <= m_rd;
                rused <= m_rused;
                wa <= m_wa;
                wd <= m_wd;
                wused <= m_wused;
                ovf <= m_ovf;
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            z80fi_valid <= 1'b0;
            z80fi_insn <= '0;
            z80fi_insn_len <= '0;
            z80fi_regs_in <= '0;
            z80fi_regs_out <= '0;
            z80fi_bus_raddr <= '0;
            z80fi_bus_raddr2 <= '0;
            z80fi_bus_waddr <= '0;
            z80fi_bus_waddr2 <= '0;
            z80fi_bus_rdata <= '0;
            z80fi_bus_rdata2 <= '0;
            z80fi_bus_wdata <= '0;
            z80fi_bus_wdata2 <= '0;
            z80fi_mem_rd <= '0;
            z80fi_mem_wr <= '0;
            z80fi_overflow <= 1'b0;
        end else begin
            z80fi_valid <= retire_pkt;
            if (retire_pkt) begin
                z80fi_insn <= m_insn;
                z80fi_insn_len <= m_len;
                z80fi_regs_in <= regs_in_buf;
                z80fi_regs_out <= core_regs;
                z80fi_bus_raddr <= m_ra[0];
                z80fi_bus_raddr2 <= m_ra[1];
                z80fi_bus_waddr <= m_wa[0];
                z80fi_bus_waddr2 <= m_wa[1];
                z80fi_bus_rdata <= m_rd[0];
                z80fi_bus_rdata2 <= m_rd[1];
                z80fi_bus_wdata <= m_wd[0];
                z80fi_bus_wdata2 <= m_wd[1];
                z80fi_mem_rd <= m_rused;
                z80fi_mem_wr <= m_wused;
                z80fi_overflow <= m_ovf;
            end
        end
    end
`ifdef Z80FI_ORDER_EN
    logic [31:0] order_cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            order_cnt <= '0;
            z80fi_order <= '0;
        end else if (retire_pkt) begin
            z80fi_order <= order_cnt;
            order_cnt <= order_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_z80fi_recorder.sv
// tb_z80fi_recorder: randomized and directed checks of z80fi_recorder against a queue-based packet model.
module tb_z80fi_recorder;
    logic clk = 1'b0, reset_n = 1'b0;
    logic insn_start = 0, insn_retire = 0, fetch_valid = 0, rd_valid = 0, wr_valid = 0;
    logic [7:0] fetch_data = 0, rd_data = 0, wr_data = 0;
    logic [15:0] rd_addr = 0, wr_addr = 0;
    logic [207:0] core_regs = 0;
    logic z80fi_valid, z80fi_overflow;
    logic [31:0] z80fi_insn;
    logic [2:0] z80fi_insn_len;
    logic [207:0] z80fi_regs_in, z80fi_regs_out;
    logic [15:0] z80fi_bus_raddr, z80fi_bus_raddr2, z80fi_bus_waddr, z80fi_bus_waddr2;
    logic [7:0] z80fi_bus_rdata, z80fi_bus_rdata2, z80fi_bus_wdata, z80fi_bus_wdata2;
    logic [1:0] z80fi_mem_rd, z80fi_mem_wr;
`ifdef Z80FI_ORDER_EN
    logic [31:0] z80fi_order;
`endif
    z80fi_recorder dut (
        .clk(clk), .reset_n(reset_n), .insn_start(insn_start), .insn_retire(insn_retire),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .core_regs(core_regs),
        .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
        .z80fi_regs_in(z80fi_regs_in), .z80fi_regs_out(z80fi_regs_out),
        .z80fi_bus_raddr(z80fi_bus_raddr), .z80fi_bus_raddr2(z80fi_bus_raddr2),
        .z80fi_bus_waddr(z80fi_bus_waddr), .z80fi_bus_waddr2(z80fi_bus_waddr2),
        .z80fi_bus_rdata(z80fi_bus_rdata), .z80fi_bus_rdata2(z80fi_bus_rdata2),
        .z80fi_bus_wdata(z80fi_bus_wdata), .z80fi_bus_wdata2(z80fi_bus_wdata2),
        .z80fi_mem_rd(z80fi_mem_rd), .z80fi_mem_wr(z80fi_mem_wr), .z80fi_overflow(z80fi_overflow)
`ifdef Z80FI_ORDER_EN
        , .z80fi_order(z80fi_order)
`endif
    );
    always #5 clk = ~clk;
    logic [551:0] dut_pkt;
    assign dut_pkt = {z80fi_insn, z80fi_insn_len, z80fi_regs_in, z80fi_regs_out,
                      z80fi_bus_raddr, z80fi_bus_rdata, z80fi_bus_raddr2, z80fi_bus_rdata2,
                      z80fi_bus_waddr, z80fi_bus_wdata, z80fi_bus_waddr2, z80fi_bus_wdata2,
                      z80fi_mem_rd, z80fi_mem_wr, z80fi_overflow};
    int vectors = 0, miscompares = 0;
    logic [7:0] fq[$], rdq[$], wdq[$];
    logic [15:0] raq[$], waq[$];
    logic [207:0] m_regs_in;
    logic [551:0] exp_pkt = '0;
    logic [31:0] pkt_count = 0, exp_order = 0;

    function automatic logic [551:0] model_pkt(input logic [207:0] rout);
        logic [31:0] ins = '0;
        logic [15:0] a0 = 0, a1 = 0, b0 = 0, b1 = 0;
        logic [7:0] d0 = 0, d1 = 0, e0 = 0, e1 = 0;
        int nf = fq.size() > 4 ? 4 : fq.size();
        logic ovf = fq.size() > 4 || raq.size() > 2 || waq.size() > 2;
        logic [1:0] mr = raq.size() >= 2 ? 2'b11 : raq.size() == 1 ? 2'b01 : 2'b00;
        logic [1:0] mw = waq.size() >= 2 ? 2'b11 : waq.size() == 1 ? 2'b01 : 2'b00;
        for (int i = 0; i < nf; i++) ins[8*i +: 8] = fq[i];
        if (raq.size() > 0) begin a0 = raq[0]; d0 = rdq[0]; end
        if (raq.size() > 1) begin a1 = raq[1]; d1 = rdq[1]; end
        if (waq.size() > 0) begin b0 = waq[0]; e0 = wdq[0]; end
        if (waq.size() > 1) begin b1 = waq[1]; e1 = wdq[1]; end
        return {ins, 3'(nf), m_regs_in, rout, a0, d0, a1, d1, b0, e0, b1, e1, mr, mw, ovf};
    endfunction

    task automatic rand_regs(output logic [207:0] r);
        for (int k = 0; k < 13; k++) r[16*k +: 16] = 16'($urandom);
    endtask

    task automatic clear_model;
        fq.delete(); rdq.delete(); wdq.delete(); raq.delete(); waq.delete();
    endtask

    task automatic zero_inputs;
        insn_start = 0; insn_retire = 0; fetch_valid = 0; rd_valid = 0; wr_valid = 0;
    endtask

    task automatic open_insn;
        logic [207:0] r;
        rand_regs(r);
        core_regs = r;
        insn_start = 1;
        m_regs_in = r;
        clear_model();
        @(negedge clk);
        zero_inputs();
    endtask

    // Spreads nf/nr/nw events over random cycles; the final cycle retires (and restarts when chain).
    task automatic body(input int nf, input int nr, input int nw, input bit chain);
        int f = nf, r = nr, w = nw;
        bit last;
        logic [207:0] rg;
        do begin
            fetch_valid = (f > 0) && ($urandom_range(1, 0) == 1);
            rd_valid = (r > 0) && ($urandom_range(1, 0) == 1);
            wr_valid = (w > 0) && ($urandom_range(1, 0) == 1);
            fetch_data = 8'($urandom); rd_addr = 16'($urandom); rd_data = 8'($urandom);
            wr_addr = 16'($urandom); wr_data = 8'($urandom);
            if (fetch_valid) begin fq.push_back(fetch_data); f--; end
            if (rd_valid) begin raq.push_back(rd_addr); rdq.push_back(rd_data); r--; end
            if (wr_valid) begin waq.push_back(wr_addr); wdq.push_back(wr_data); w--; end
            last = (f == 0 && r == 0 && w == 0);
            rand_regs(rg);
            core_regs = rg;
            insn_retire = last;
            insn_start = last && chain;
            if (last) begin
                exp_pkt = model_pkt(rg);
                exp_order = pkt_count;
                pkt_count++;
                if (chain) begin m_regs_in = rg; clear_model(); end
            end
            @(negedge clk);
        end while (!last);
        zero_inputs();
    endtask

    task automatic test_reset;
        vectors++;
        if (z80fi_valid !== 1'b0 || dut_pkt !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs valid=%b pkt=%h expected all zero", z80fi_valid, dut_pkt);
        end
`ifdef Z80FI_ORDER_EN
        vectors++;
        if (z80fi_order !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_order got %h expected 0", z80fi_order);
        end
`endif
    endtask

    task automatic test_ld_bc;
        logic [7:0] bytes [4] = '{8'hED, 8'h4B, 8'h34, 8'h12};
        logic [207:0] r;
        open_insn();
        for (int i = 0; i < 4; i++) begin
            fetch_valid = 1; fetch_data = bytes[i];
            @(negedge clk);
        end
        fetch_valid = 0;
        rd_valid = 1; rd_addr = 16'h1234; rd_data = 8'h56;
        @(negedge clk);
        rand_regs(r);
        r[191:176] = 16'h7856;
        rd_addr = 16'h1235; rd_data = 8'h78; insn_retire = 1; core_regs = r;
        pkt_count++;
        @(negedge clk);
        zero_inputs();
        vectors++;
        if (z80fi_valid !== 1'b1) begin miscompares++; $display("FAIL ldbc_valid got %b expected 1", z80fi_valid); end
        vectors++;
        if (z80fi_insn !== 32'h12344BED || z80fi_insn_len !== 3'd4) begin
            miscompares++; $display("FAIL ldbc_insn got %h/%0d expected 12344bed/4", z80fi_insn, z80fi_insn_len);
        end
        vectors++;
        if ({z80fi_bus_raddr, z80fi_bus_rdata, z80fi_bus_raddr2, z80fi_bus_rdata2} !== 48'h1234_56_1235_78) begin
            miscompares++; $display("FAIL ldbc_reads got %h %h %h %h expected 1234 56 1235 78",
                z80fi_bus_raddr, z80fi_bus_rdata, z80fi_bus_raddr2, z80fi_bus_rdata2);
        end
        vectors++;
        if (z80fi_mem_rd !== 2'b11 || z80fi_mem_wr !== 2'b00 || z80fi_regs_out[191:176] !== 16'h7856) begin
            miscompares++; $display("FAIL ldbc_flags got rd=%b wr=%b bc=%h expected 11 00 7856",
                z80fi_mem_rd, z80fi_mem_wr, z80fi_regs_out[191:176]);
        end
        @(negedge clk);
        vectors++;
        if (z80fi_valid !== 1'b0 || z80fi_insn !== 32'h12344BED) begin
            miscompares++; $display("FAIL ldbc_hold valid=%b insn=%h expected 0 12344bed", z80fi_valid, z80fi_insn);
        end
    endtask

    task automatic test_random;
        bit opened = 0, chain;
        for (int n = 0; n < 40; n++) begin
            if (!opened) open_insn();
            chain = $urandom_range(1, 0) == 1;
            body($urandom_range(4, 0), $urandom_range(2, 0), $urandom_range(2, 0), chain);
            opened = chain;
            vectors++;
            if (z80fi_valid !== 1'b1 || dut_pkt !== exp_pkt) begin
                miscompares++; $display("FAIL random_pkt valid=%b got %h expected %h", z80fi_valid, dut_pkt, exp_pkt);
            end
`ifdef Z80FI_ORDER_EN
            vectors++;
            if (z80fi_order !== exp_order) begin
                miscompares++; $display("FAIL random_order got %h expected %h", z80fi_order, exp_order);
            end
`endif
            if (!chain) begin
                @(negedge clk);
                vectors++;
                if (z80fi_valid !== 1'b0 || dut_pkt !== exp_pkt) begin
                    miscompares++; $display("FAIL random_hold valid=%b got %h expected %h", z80fi_valid, dut_pkt, exp_pkt);
                end
            end
        end
        if (opened) body(0, 0, 0, 0);
        @(negedge clk);
    endtask

    task automatic test_overflow;
        int cfg [3][3] = '{'{5, 1, 0}, '{1, 3, 1}, '{0, 1, 3}};
        for (int c = 0; c < 3; c++) begin
            open_insn();
            body(cfg[c][0], cfg[c][1], cfg[c][2], 0);
            vectors++;
            if (dut_pkt !== exp_pkt || z80fi_overflow !== 1'b1) begin
                miscompares++; $display("FAIL overflow_%0d ovf=%b got %h expected %h", c, z80fi_overflow, dut_pkt, exp_pkt);
            end
        end
        open_insn();
        body(2, 1, 1, 0);
        vectors++;
        if (dut_pkt !== exp_pkt || z80fi_overflow !== 1'b0) begin
            miscompares++; $display("FAIL overflow_clear ovf=%b got %h expected %h", z80fi_overflow, dut_pkt, exp_pkt);
        end
        @(negedge clk);
    endtask

    task automatic test_coincident;
        logic [207:0] r1, r2;
        open_insn();
        fetch_valid = 1; fetch_data = 8'h11;
        @(negedge clk);
        rand_regs(r1);
        fetch_data = 8'h00; insn_retire = 1; insn_start = 1; core_regs = r1;
        pkt_count++;
        @(negedge clk);
        zero_inputs();
        vectors++;
        if (z80fi_valid !== 1'b1 || z80fi_insn !== 32'h00000011 || z80fi_insn_len !== 3'd2) begin
            miscompares++; $display("FAIL coincident_merge valid=%b insn=%h len=%0d expected 1 00000011 2",
                z80fi_valid, z80fi_insn, z80fi_insn_len);
        end
        rand_regs(r2);
        insn_retire = 1; core_regs = r2;
        pkt_count++;
        @(negedge clk);
        zero_inputs();
        vectors++;
        if (z80fi_valid !== 1'b1 || z80fi_insn_len !== 3'd0 || z80fi_insn !== 32'd0 || z80fi_regs_in !== r1) begin
            miscompares++; $display("FAIL coincident_next valid=%b len=%0d insn=%h regs_in=%h expected 1 0 0 %h",
                z80fi_valid, z80fi_insn_len, z80fi_insn, z80fi_regs_in, r1);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        open_insn();
        for (int i = 0; i < 5; i++) begin
            body(0, 0, 0, i < 4);
            vectors++;
            if (z80fi_valid !== 1'b1 || dut_pkt !== exp_pkt) begin
                miscompares++; $display("FAIL b2b_%0d valid=%b got %h expected %h", i, z80fi_valid, dut_pkt, exp_pkt);
            end
        end
        @(negedge clk);
        vectors++;
        if (z80fi_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_end valid=%b expected 0", z80fi_valid); end
    endtask

    task automatic test_stray;
        insn_retire = 1; fetch_valid = 1; fetch_data = 8'hAA; rd_valid = 1; wr_valid = 1;
        core_regs = ~core_regs;
        @(negedge clk);
        zero_inputs();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (z80fi_valid !== 1'b0 || dut_pkt !== exp_pkt) begin
                miscompares++; $display("FAIL stray_%0d valid=%b got %h expected %h", i, z80fi_valid, dut_pkt, exp_pkt);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        open_insn();
        for (int i = 0; i < 2; i++) begin
            fetch_valid = 1; fetch_data = 8'($urandom);
            @(negedge clk);
        end
        fetch_valid = 0;
        reset_n = 0;
        #1;
        vectors++;
        if (z80fi_valid !== 1'b0 || dut_pkt !== '0) begin
            miscompares++; $display("FAIL reset_mid_async valid=%b pkt=%h expected all zero", z80fi_valid, dut_pkt);
        end
        @(negedge clk);
        reset_n = 1;
        pkt_count = 0;
        exp_pkt = '0;
        insn_retire = 1;
        @(negedge clk);
        zero_inputs();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (z80fi_valid !== 1'b0 || dut_pkt !== '0) begin
                miscompares++; $display("FAIL reset_mid_%0d valid=%b pkt=%h expected all zero", i, z80fi_valid, dut_pkt);
            end
            @(negedge clk);
        end
    endtask

`ifdef Z80FI_ORDER_EN
    task automatic test_order_wrap;
        force dut.order_cnt = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.order_cnt;
        pkt_count = 32'hFFFFFFFF;
        for (int i = 0; i < 2; i++) begin
            open_insn();
            body(1, 0, 0, 0);
            vectors++;
            if (z80fi_valid !== 1'b1 || z80fi_order !== exp_order) begin
                miscompares++; $display("FAIL order_wrap_%0d valid=%b got %h expected %h", i, z80fi_valid, z80fi_order, exp_order);
            end
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        reset_n = 1;
        @(negedge clk);
        test_ld_bc();
        test_random();
        test_overflow();
        test_coincident();
        test_back_to_back();
        test_stray();
        test_reset_mid();
        test_random();
`ifdef Z80FI_ORDER_EN
        test_order_wrap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
